// File: rtl/dcache_miss_ctrl.sv
// Blocking miss sequencer between the LSQ, dcache_mem and the memory port.
// DCACHE_WRITE_ALLOCATE_EN: store misses fill the line instead of writing around.
module dcache_miss_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_BITS = 64,
    localparam int TAG_BITS = ADDR_BITS - 3 - INDEX_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_is_store,
    input  logic [ADDR_BITS-1:0]  req_addr,
    input  logic [63:0]           req_data,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [63:0]           resp_data,
    output logic [INDEX_BITS-1:0] cache_index,
    output logic [TAG_BITS-1:0]   cache_tag,
    output logic                  cache_rd_en,
    output logic                  cache_wr_en,
    output logic                  cache_fill,
    output logic [63:0]           cache_wr_data,
    output logic                  cache_wb_en,
    input  logic                  cache_hit,
    input  logic                  cache_dirty,
    input  logic [TAG_BITS-1:0]   cache_victim_tag,
    input  logic [63:0]           cache_rd_data,
    output logic [1:0]            mem_cmd,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [63:0]           mem_wdata,
    input  logic [3:0]            mem_response,
    input  logic [3:0]            mem_tag,
    input  logic [63:0]           mem_rdata
);

    localparam int BLK_BITS = ADDR_BITS - 3;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOOKUP  = 3'd1;
    localparam logic [2:0] WB      = 3'd2;
    localparam logic [2:0] LD_REQ  = 3'd3;
    localparam logic [2:0] LD_WAIT = 3'd4;
    localparam logic [2:0] FILL    = 3'd5;
    localparam logic [2:0] RESP    = 3'd6;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    logic [2:0]          state;
    logic [BLK_BITS-1:0] blk_q;
    logic [63:0]         data_q;
    logic                is_store_q;
    logic [3:0]          tag_q;
    logic                mem_ack;
    logic                unused_offset;

    assign mem_ack = mem_response != 4'd0;
    assign unused_offset = ^req_addr[2:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            blk_q      <= '0;
            data_q     <= '0;
            is_store_q <= 1'b0;
            tag_q      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        blk_q      <= req_addr[ADDR_BITS-1:3];
                        data_q     <= req_data;
                        is_store_q <= req_is_store;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        if (!is_store_q)
                            data_q <= cache_rd_data;
                        state <= RESP;
                    end else begin
`ifdef DCACHE_WRITE_ALLOCATE_EN
                        if (cache_dirty)
                            state <= WB;
                        else
                            state <= is_store_q ? FILL : LD_REQ;
`else
                        // Store misses bypass the cache entirely: no victim eviction.
                        if (cache_dirty && !is_store_q)
                            state <= WB;
                        else
                            state <= LD_REQ;
`endif
                    end
                end
                WB: begin
                    if (mem_ack)
                        state <= is_store_q ? FILL : LD_REQ;
                end
                LD_REQ: begin
                    if (mem_ack) begin
                        if (is_store_q) begin
                            state <= RESP;
                        end else begin
                            tag_q <= mem_response;
                            state <= LD_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    if (mem_tag != 4'd0 && mem_tag == tag_q) begin
                        data_q <= mem_rdata;
                        state  <= FILL;
                    end
                end
                FILL: state <= RESP;
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_data  <= is_store_q ? 64'd0 : data_q;
                    tag_q      <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = state == IDLE;
    assign cache_index   = blk_q[INDEX_BITS-1:0];
    assign cache_tag     = blk_q[BLK_BITS-1:INDEX_BITS];
    assign cache_rd_en   = state == LOOKUP;
    assign cache_wb_en   = state == WB;
    assign cache_wr_data = data_q;
    assign cache_fill    = (state == FILL) && !is_store_q;
    assign cache_wr_en   = (state == FILL) ||
                           ((state == LOOKUP) && cache_hit && is_store_q);

    always_comb begin
        mem_cmd   = CMD_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            WB: begin
                mem_cmd   = CMD_STORE;
                mem_addr  = {cache_victim_tag, cache_index, 3'b000};
                mem_wdata = cache_rd_data;
            end
            LD_REQ: begin
                mem_cmd  = is_store_q ? CMD_STORE : CMD_LOAD;
                mem_addr = {blk_q, 3'b000};
                if (is_store_q)
                    mem_wdata = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Blocking sequencer between the load/store queue and the data cache array (dcache_mem) plus the memory interface.
- Accepts one request at a time and runs the cache lookup.
- On a miss it writes back a dirty victim, issues the memory load, waits for the matching tag and fills the line, then returns the response.
- Owns every dcache_mem control strobe; dcache_mem has no other driver.

Parameters:
- INDEX_BITS, 4, cache index width (16 sets, direct-mapped).
- ADDR_BITS, 64, byte address width; offset fixed at 3 bits (8-byte block); TAG_BITS = ADDR_BITS-3-INDEX_BITS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  LSQ request valid.
- req_is_store  in  1  1=store, 0=load.
- req_addr  in  ADDR_BITS  byte address; offset bits ignored.
- req_data  in  64  store block data.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  64  load block data; 0 for stores.
- cache_index  out  INDEX_BITS  index to dcache_mem.
- cache_tag  out  TAG_BITS  tag to dcache_mem.
- cache_rd_en  out  1  read_enable to dcache_mem.
- cache_wr_en  out  1  write_enable to dcache_mem.
- cache_fill  out  1  with cache_wr_en: install the line clean (valid=1, dirty=0).
- cache_wr_data  out  64  write data to dcache_mem.
- cache_wb_en  out  1  store_to_memory_enable to dcache_mem.
- cache_hit  in  1  ~data_is_miss && data_is_valid, combinational on index/tag.
- cache_dirty  in  1  victim line dirty.
- cache_victim_tag  in  TAG_BITS  tag of the resident line.
- cache_rd_data  in  64  read_data_out / store_data_out from dcache_mem.
- mem_cmd  out  2  0=NONE, 1=LOAD, 2=STORE.
- mem_addr  out  ADDR_BITS  block address; low 3 bits are 0.
- mem_wdata  out  64  writeback data.
- mem_response  in  4  transaction tag; 0 = rejected.
- mem_tag  in  4  completing tag; 0 = none.
- mem_rdata  in  64  load return data.

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs 0 except req_ready=1; latched request and pending tag cleared.
- States: IDLE, LOOKUP, WB, LD_REQ, LD_WAIT, FILL, RESP.
- IDLE: a handshake on req_valid&&req_ready latches addr/data/is_store -> LOOKUP.
- LOOKUP: drive index/tag and cache_rd_en=1 for 1 cycle.
  - Load hit: latch cache_rd_data -> RESP.
  - Store hit: cache_wr_en=1 with req data (line becomes dirty) -> RESP.
  - Miss with cache_dirty=1 -> WB.
  - Load miss, clean -> LD_REQ.
  - Store miss, clean: see Optional Feature.
- WB: mem_cmd=STORE, mem_addr={victim_tag,index,3'b0}, mem_wdata=cache_rd_data, cache_wb_en=1. Held every cycle until mem_response!=0; then LD_REQ for a load, or the store-miss path for a store.
- LD_REQ: mem_cmd=LOAD, mem_addr={tag,index,3'b0}. Held until mem_response!=0; that tag is latched -> LD_WAIT.
- LD_WAIT: mem_cmd=NONE. When mem_tag==latched tag and mem_tag!=0, capture mem_rdata -> FILL. mem_tag values that do not match are ignored.
- A mem_tag arriving in the same cycle as mem_response is not the completion of that request; only later cycles count.
- FILL: cache_wr_en=1 with cache_fill=1 and the captured data -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready is 0 from LOOKUP through RESP.
- Hit latency: accept at edge N, resp_valid high in the cycle after edge N+2.
- Outputs are registered or decoded from state only; no combinational path from req_* to mem_*.
- reset asserted mid-transaction: abort immediately; the pending memory tag is discarded, and any later completion carrying it is ignored.

Optional Feature:
- Macro: DCACHE_WRITE_ALLOCATE_EN.
- Defined: a store miss (after WB if the victim was dirty) writes req_data into the line with cache_wr_en=1, cache_fill=0, so the line ends dirty. No memory load is issued. -> RESP.
- Undefined: a store miss does not touch the cache and no WB is performed. It issues mem_cmd=STORE to {tag,index,3'b0} with mem_wdata=req_data, retried until mem_response!=0 -> RESP.

Test Plan:
- Reset released, load idx=2 tag=1, cache miss clean; mem_response=1, then mem_tag=1 with mem_rdata=0xffff -> LOAD issued once, FILL writes 0xffff clean, resp_data=0xffff.
- Load idx=2 tag=1 again with the cache reporting a hit -> no mem_cmd, resp_valid 3 cycles after accept, data returned.
- Store 0xcccc to idx=3 tag=2 (hit), then a load of idx=3 tag=5 with the line dirty and victim_tag=2 -> WB STORE to {2,3,000} with data 0xcccc, then LOAD of tag 5.
- mem_response=0 for 3 cycles during LD_REQ -> mem_cmd=LOAD held all 4 cycles; the tag latched only on the nonzero response.
- In LD_WAIT, mem_tag=4 while waiting on 3, then mem_tag=3 -> the tag-4 return is ignored; completion happens on 3.
- Store miss with the macro undefined -> mem STORE of req_data, cache_wr_en never asserted.
- Store miss with the macro defined -> cache_wr_en=1, cache_fill=0, no mem LOAD.
- reset pulsed low in LD_WAIT, then the stale mem_tag arrives -> state IDLE, no resp_valid, no FILL.
